cursor_outline_blinker: RTL and testbench
=========================================

Name: cursor_outline_blinker

Overview:
Parametrised successor to the palette-cursor controller. Draws the outline of a square cursor by emitting pixel writes edge by edge: right, down, left, up. It then alternates between an "on" colour and an "off" colour for a programmable number of blink pairs. It owns its step and hold counters instead of relying on external counter and compare inputs. It drives the framebuffer write port through a valid/ready handshake and sits between the paint controller and the framebuffer arbiter.

Parameters:
COORD_W, 6, width of the x/y coordinates; arithmetic wraps modulo 2^COORD_W.
PX_W, 8, pixel data width.
CNT_W, 24, width of the hold counter.
ON_CYCLES, 1000, idle cycles held after an on-pass completes (0 means no hold).
OFF_CYCLES, 1000, idle cycles held after an off-pass completes, except the final pass.
BLINKS, 2, number of on/off pass pairs (at least 1).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
init  in  1  start request; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE
x0  in  COORD_W  top-left x; latched at init
y0  in  COORD_W  top-left y; latched at init
side_len  in  COORD_W  side length in pixels; latched at init
color_on  in  PX_W  on colour; latched at init
color_off  in  PX_W  off colour; latched at init
wr_valid  out  1  pixel write request
wr_ready  in  1  arbiter accepts the write
wr_x  out  COORD_W  write x coordinate
wr_y  out  COORD_W  write y coordinate
wr_data  out  PX_W  write colour
busy  out  1  high in every state except IDLE
phase  out  1  0 during on-passes and holds, 1 during off-passes and holds
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: rst puts the block in IDLE. All outputs are 0; internal counters and latches are cleared.
- States: IDLE, EDGE_R, EDGE_D, EDGE_L, EDGE_U, HOLD, DONE.
- Start:
  - IDLE with init=1 and abort=0 latches all inputs.
  - Pass counter clears, phase=0, and the state moves to EDGE_R.
  - The first wr_valid appears in the cycle after init.
- Edge traversal, with L=side_len. Each edge emits L-1 pixels, and the step counter resets at every edge change:
  - EDGE_R: (x0+i, y0) for i = 0..L-2.
  - EDGE_D: (x0+L-1, y0+i).
  - EDGE_L: (x0+L-1-i, y0+L-1).
  - EDGE_U: (x0, y0+L-1-i).
  - Each outline pixel is written exactly once, 4(L-1) writes per pass.
  - Edge order is fixed. An edge moves to the next edge (or to HOLD after EDGE_U) in the cycle after its last pixel is accepted.
- L=1: each pass is a single write at (x0,y0), issued from EDGE_R. The remaining edges are skipped with zero cycles spent in them.
- L=0: no writes. Passes and holds are still sequenced, so only the blink timing is observable.
- Handshake:
  - A transfer occurs when wr_valid=1 and wr_ready=1.
  - While wr_valid=1 and wr_ready=0, wr_x, wr_y and wr_data stay stable.
  - A new pixel may be presented in the cycle after a transfer, giving a throughput of 1 pixel per cycle with wr_ready held high.
  - wr_data is color_on when phase=0 and color_off when phase=1.
  - wr_valid=0 in IDLE, HOLD and DONE.
- HOLD:
  - Lasts exactly ON_CYCLES (phase 0) or OFF_CYCLES (phase 1) cycles, then returns to EDGE_R with phase toggled.
  - A hold count of 0 means HOLD is passed through in zero cycles.
- Final pass: after the off-pass of blink pair BLINKS ends, the off-hold is skipped. The state goes directly to DONE, where done=1 for one cycle, then IDLE.
- Abort:
  - abort=1 in any non-IDLE state causes IDLE in the next cycle and wr_valid drops, even mid-handshake.
  - The dropped write is not counted, and done is not pulsed.
  - If abort and init arrive in the same IDLE cycle, abort wins.
- Overlap rules:
  - init while busy is ignored.
  - Input changes while busy have no effect.
  - rst mid-operation behaves like abort, with all outputs cleared.
- Coordinates wrap silently; there is no clipping.

Decomposition:
- Shared package cursor_pkg holds:
  - the state encoding constants;
  - default PX_W and COORD_W;
  - the colour constants WHITE=8'hFF and BLACK=8'h00, which are the default colours used by the paint controller.
- One natural sub-module: hold_timer. It is a loadable CNT_W down-counter with load, enable and zero outputs, used for the HOLD state.
- The step counter and the coordinate generator stay inline.

Test Plan:
1. L=3, x0=10, y0=20, BLINKS=1, hold=4, wr_ready=1. Required: 8 on-writes in the order (10,20) (11,20) (12,20) (12,21) (12,22) (11,22) (10,22) (10,21), then 4 cycles with wr_valid=0. Then the same 8 coordinates with color_off, then done one cycle after the last write.
2. Same as 1 with wr_ready toggling 1-0-0-1 pseudo-randomly. Required: payload stable during every stall, no pixel duplicated or lost, same sequence as 1.
3. L=1 and L=0, BLINKS=2. Required: for L=1, 4 writes total, all at (x0,y0), alternating on, off, on, off. For L=0, zero writes, with done arriving after 3 hold periods.
4. x0=62, y0=62, L=4, COORD_W=6. Required: the coordinate sequence wraps through 0 and 1 as expected, for example (63,62) (0,62) (1,62).
5. abort raised during the second pixel with wr_ready=0. Required: wr_valid=0 and busy=0 in the next cycle, no done pulse. An init two cycles later restarts cleanly from (x0,y0).
6. init asserted while busy and init+abort asserted together in IDLE. Required: both ignored, and the latched x0 is unchanged.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor outline blinker: state encoding, default widths and
// the paint controller's default colours.
package cursor_pkg;

  localparam int unsigned DEF_COORD_W = 6;
  localparam int unsigned DEF_PX_W    = 8;

  localparam logic [7:0] WHITE = 8'hFF;
  localparam logic [7:0] BLACK = 8'h00;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_EDGE_R = 3'd1;
  localparam state_t ST_EDGE_D = 3'd2;
  localparam state_t ST_EDGE_L = 3'd3;
  localparam state_t ST_EDGE_U = 3'd4;
  localparam state_t ST_HOLD   = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

endpackage

// File: rtl/cursor_outline_blinker_hold_timer.sv
// Loadable down-counter that times the idle hold between outline passes.
module hold_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/cursor_outline_blinker.sv
// Draws a square cursor outline edge by edge, then alternates on/off colour passes
// separated by programmable holds, writing pixels through a valid/ready port.
module cursor_outline_blinker
  import cursor_pkg::*;
#(
  parameter int unsigned COORD_W    = DEF_COORD_W,
  parameter int unsigned PX_W       = DEF_PX_W,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned ON_CYCLES  = 1000,
  parameter int unsigned OFF_CYCLES = 1000,
  parameter int unsigned BLINKS     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] side_len,
  input  logic [PX_W-1:0]    color_on,
  input  logic [PX_W-1:0]    color_off,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [PX_W-1:0]    wr_data,
  output logic               busy,
  output logic               phase,
  output logic               done
);

  localparam int unsigned PASS_W = (BLINKS > 1) ? $clog2(BLINKS) : 1;
  // The timer counts down to zero inclusive, so load one less than the hold length.
  localparam logic [CNT_W-1:0] ON_LOAD  = (ON_CYCLES == 0) ? '0 : CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = (OFF_CYCLES == 0) ? '0 : CNT_W'(OFF_CYCLES - 1);
  localparam bit ON_NONE  = (ON_CYCLES == 0);
  localparam bit OFF_NONE = (OFF_CYCLES == 0);

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [COORD_W-1:0]  step_q, step_d;
  logic [COORD_W-1:0]  x0_q, y0_q, len_q;
  logic [PX_W-1:0]     con_q, coff_q;

  logic               latch, end_pass, xfer, last, in_edge, empty, single;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]   tmr_load_val;
  logic [COORD_W-1:0] len_m1, px, py;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    len_m1  = len_q - COORD_W'(1);
    empty   = (len_q == '0);
    single  = (len_q == COORD_W'(1));
    in_edge = (state_q == ST_EDGE_R) || (state_q == ST_EDGE_D) ||
              (state_q == ST_EDGE_L) || (state_q == ST_EDGE_U);
    last    = single || (step_q == (len_q - COORD_W'(2)));
    px      = x0_q;
    py      = y0_q;
    case (state_q)
      ST_EDGE_R: begin px = x0_q + step_q;          py = y0_q;                   end
      ST_EDGE_D: begin px = x0_q + len_m1;          py = y0_q + step_q;          end
      ST_EDGE_L: begin px = x0_q + len_m1 - step_q; py = y0_q + len_m1;          end
      ST_EDGE_U: begin px = x0_q;                   py = y0_q + len_m1 - step_q; end
      default:   ;
    endcase
    wr_valid = in_edge && !empty;
    xfer     = wr_valid && wr_ready;
    // Payload is forced to zero when no request is pending.
    wr_x     = wr_valid ? px : '0;
    wr_y     = wr_valid ? py : '0;
    wr_data  = !wr_valid ? '0 : (phase_q ? coff_q : con_q);
    busy     = (state_q != ST_IDLE);
    phase    = phase_q;
    done     = (state_q == ST_DONE);
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pass_d       = pass_q;
    step_d       = step_q;
    latch        = 1'b0;
    end_pass     = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_load_val = phase_q ? OFF_LOAD : ON_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (init && !abort) begin
          latch   = 1'b1;
          state_d = ST_EDGE_R;
          phase_d = 1'b0;
          pass_d  = '0;
          step_d  = '0;
        end
      end
      ST_EDGE_R: begin
        if (empty || (xfer && single)) begin
          end_pass = 1'b1;
        end else if (xfer) begin
          if (last) begin
            state_d = ST_EDGE_D;
            step_d  = '0;
          end else begin
            step_d = step_q + COORD_W'(1);
          end
        end
      end
      ST_EDGE_D, ST_EDGE_L: begin
        if (xfer) begin
          if (last) begin
            state_d = (state_q == ST_EDGE_D) ? ST_EDGE_L : ST_EDGE_U;
            step_d  = '0;
          end else begin
            step_d = step_q + COORD_W'(1);
          end
        end
      end
      ST_EDGE_U: begin
        if (xfer) begin
          if (last) end_pass = 1'b1;
          else      step_d = step_q + COORD_W'(1);
        end
      end
      ST_HOLD: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = ST_EDGE_R;
          phase_d = !phase_q;
          step_d  = '0;
          if (phase_q) pass_d = pass_q + PASS_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        phase_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_pass) begin
      step_d = '0;
      if (phase_q && (pass_q == PASS_W'(BLINKS - 1))) begin
        state_d = ST_DONE;
      end else if (phase_q ? OFF_NONE : ON_NONE) begin
        state_d = ST_EDGE_R;
        phase_d = !phase_q;
        if (phase_q) pass_d = pass_q + PASS_W'(1);
      end else begin
        state_d  = ST_HOLD;
        tmr_load = 1'b1;
      end
    end

    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      phase_d  = 1'b0;
      pass_d   = '0;
      step_d   = '0;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      pass_q  <= '0;
      step_q  <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      len_q   <= '0;
      con_q   <= '0;
      coff_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pass_q  <= pass_d;
      step_q  <= step_d;
      if (latch) begin
        x0_q   <= x0;
        y0_q   <= y0;
        len_q  <= side_len;
        con_q  <= color_on;
        coff_q <= color_off;
      end
    end
  end

endmodule

// File: tb/tb_cursor_outline_blinker.sv
// Directed bench for cursor_outline_blinker: two instances with different blink/hold settings.
module tb_cursor_outline_blinker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init1 = 1'b0, init2 = 1'b0, abort = 1'b0, wr_ready = 1'b1;
  logic [5:0] x0 = '0, y0 = '0, side_len = '0;
  logic [7:0] color_on = '0, color_off = '0;

  logic       v1, b1, ph1, d1, v2, b2, ph2, d2;
  logic [5:0] x1, y1, x2, y2;
  logic [7:0] wd1, wd2;

  int checks = 0;
  int errors = 0;

  int wx[64], wy[64], wd[64], wc[64];
  int n_wr, done_at, stall_bad;

  int exp1x[8] = '{10, 11, 12, 12, 12, 11, 10, 10};
  int exp1y[8] = '{20, 20, 20, 21, 22, 22, 22, 21};
  int exp4x[12] = '{62, 63, 0, 1, 1, 1, 1, 0, 63, 62, 62, 62};
  int exp4y[12] = '{62, 62, 62, 62, 63, 0, 1, 1, 1, 1, 0, 63};

  always #5 clk = ~clk;

  cursor_outline_blinker #(
    .COORD_W (6), .PX_W (8), .CNT_W (8), .ON_CYCLES (4), .OFF_CYCLES (4), .BLINKS (1)
  ) dut1 (
    .clk (clk), .rst (rst), .init (init1), .abort (abort), .x0 (x0), .y0 (y0),
    .side_len (side_len), .color_on (color_on), .color_off (color_off),
    .wr_valid (v1), .wr_ready (wr_ready), .wr_x (x1), .wr_y (y1), .wr_data (wd1),
    .busy (b1), .phase (ph1), .done (d1)
  );

  cursor_outline_blinker #(
    .COORD_W (6), .PX_W (8), .CNT_W (8), .ON_CYCLES (3), .OFF_CYCLES (3), .BLINKS (2)
  ) dut2 (
    .clk (clk), .rst (rst), .init (init2), .abort (abort), .x0 (x0), .y0 (y0),
    .side_len (side_len), .color_on (color_on), .color_off (color_off),
    .wr_valid (v2), .wr_ready (wr_ready), .wr_x (x2), .wr_y (y2), .wr_data (wd2),
    .busy (b2), .phase (ph2), .done (d2)
  );

  task automatic start(input int sel, input int x, input int y, input int l,
                       input logic [7:0] con, input logic [7:0] coff);
    @(negedge clk);
    x0 = 6'(x); y0 = 6'(y); side_len = 6'(l); color_on = con; color_off = coff;
    wr_ready = 1'b1;
    if (sel != 0) init2 = 1'b1;
    else          init1 = 1'b1;
    @(negedge clk);
    init1 = 1'b0; init2 = 1'b0;
  endtask

  // Runs from the current negedge until done (or budget), recording accepted writes.
  task automatic capture(input int sel, input int mode, input int poke, input int budget);
    logic cv, cdn, r, pv, pr;
    int cx, cy, cd, px, py, pd;
    n_wr = 0; done_at = -1; stall_bad = 0;
    pv = 1'b0; pr = 1'b1; px = 0; py = 0; pd = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      cv  = (sel != 0) ? v2 : v1;
      cdn = (sel != 0) ? d2 : d1;
      cx  = int'((sel != 0) ? x2 : x1);
      cy  = int'((sel != 0) ? y2 : y1);
      cd  = int'((sel != 0) ? wd2 : wd1);
      if (cyc == poke) begin
        init1 = 1'b1; x0 = 6'd5; y0 = 6'd7; side_len = 6'd5; color_on = 8'h11;
      end else if (cyc == poke + 1) begin
        init1 = 1'b0;
      end
      if (pv && !pr && !(cv && cx == px && cy == py && cd == pd)) stall_bad++;
      r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wr_ready = r;
      if (cv && r && n_wr < 64) begin
        wx[n_wr] = cx; wy[n_wr] = cy; wd[n_wr] = cd; wc[n_wr] = cyc;
        n_wr++;
      end
      pv = cv; pr = r; px = cx; py = cy; pd = cd;
      if (cdn) begin
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
    wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({v1, b1, ph1, d1, v2, b2, ph2, d2} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000000", {v1, b1, ph1, d1, v2, b2, ph2, d2});
    end
    checks++;
    if ({x1, y1, wd1, x2, y2, wd2} !== 40'h0) begin
      errors++; $display("FAIL reset_payload got %h want 0", {x1, y1, wd1, x2, y2, wd2});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_seq8(input string tag, input logic [7:0] con, input logic [7:0] coff);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (wx[i] != exp1x[i % 8] || wy[i] != exp1y[i % 8] ||
          wd[i] != int'((i < 8) ? con : coff)) begin
        errors++;
        $display("FAIL %s_px%0d got (%0d,%0d,%0h) want (%0d,%0d,%0h)", tag, i, wx[i], wy[i],
                 wd[i], exp1x[i % 8], exp1y[i % 8], (i < 8) ? con : coff);
      end
    end
  endtask

  task automatic test_basic();
    start(0, 10, 20, 3, 8'hA5, 8'h5A);
    capture(0, 0, -1, 100);
    checks++;
    if (n_wr != 16) begin errors++; $display("FAIL basic_count got %0d want 16", n_wr); end
    check_seq8("basic", 8'hA5, 8'h5A);
    checks++;
    if (wc[7] != 7 || wc[8] != 12) begin
      errors++; $display("FAIL basic_hold got %0d,%0d want 7,12", wc[7], wc[8]);
    end
    checks++;
    if (done_at != 20) begin errors++; $display("FAIL basic_done got %0d want 20", done_at); end
    @(negedge clk);
    checks++;
    if (d1 !== 1'b0 || b1 !== 1'b0) begin
      errors++; $display("FAIL basic_after_done got done=%b busy=%b want 0 0", d1, b1);
    end
  endtask

  task automatic test_stall();
    start(0, 10, 20, 3, 8'hA5, 8'h5A);
    capture(0, 1, -1, 400);
    checks++;
    if (n_wr != 16) begin errors++; $display("FAIL stall_count got %0d want 16", n_wr); end
    check_seq8("stall", 8'hA5, 8'h5A);
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stall_bad); end
    checks++;
    if (done_at != wc[15] + 1) begin
      errors++; $display("FAIL stall_done got %0d want %0d", done_at, wc[15] + 1);
    end
  endtask

  task automatic test_small();
    start(1, 7, 9, 1, 8'hC3, 8'h3C);
    capture(1, 0, -1, 100);
    checks++;
    if (n_wr != 4) begin errors++; $display("FAIL l1_count got %0d want 4", n_wr); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wx[i] != 7 || wy[i] != 9 || wd[i] != (((i % 2) == 0) ? 'hC3 : 'h3C) || wc[i] != 4 * i)
      begin
        errors++;
        $display("FAIL l1_px%0d got (%0d,%0d,%0h)@%0d want (7,9,%0h)@%0d", i, wx[i], wy[i], wd[i],
                 wc[i], ((i % 2) == 0) ? 'hC3 : 'h3C, 4 * i);
      end
    end
    checks++;
    if (done_at != 13) begin errors++; $display("FAIL l1_done got %0d want 13", done_at); end
    start(1, 7, 9, 0, 8'hC3, 8'h3C);
    capture(1, 0, -1, 100);
    checks++;
    if (n_wr != 0) begin errors++; $display("FAIL l0_count got %0d want 0", n_wr); end
    checks++;
    if (done_at != 13) begin errors++; $display("FAIL l0_done got %0d want 13", done_at); end
  endtask

  task automatic test_wrap();
    start(0, 62, 62, 4, 8'h77, 8'h88);
    capture(0, 0, -1, 100);
    checks++;
    if (n_wr != 24) begin errors++; $display("FAIL wrap_count got %0d want 24", n_wr); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (wx[i] != exp4x[i] || wy[i] != exp4y[i] || wd[i] != 'h77) begin
        errors++;
        $display("FAIL wrap_px%0d got (%0d,%0d,%0h) want (%0d,%0d,77)", i, wx[i], wy[i], wd[i],
                 exp4x[i], exp4y[i]);
      end
    end
    checks++;
    if (done_at != 28) begin errors++; $display("FAIL wrap_done got %0d want 28", done_at); end
  endtask

  task automatic test_abort();
    start(0, 10, 20, 3, 8'hA5, 8'h5A);
    checks++;
    if (v1 !== 1'b1 || x1 !== 6'd10 || y1 !== 6'd20) begin
      errors++; $display("FAIL abort_first got v=%b (%0d,%0d) want 1 (10,20)", v1, x1, y1);
    end
    @(negedge clk);
    wr_ready = 1'b0;
    abort = 1'b1;
    checks++;
    if (v1 !== 1'b1 || x1 !== 6'd11) begin
      errors++; $display("FAIL abort_second got v=%b x=%0d want 1 11", v1, x1);
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (v1 !== 1'b0 || b1 !== 1'b0 || d1 !== 1'b0) begin
      errors++; $display("FAIL abort_drop got v=%b busy=%b done=%b want 0 0 0", v1, b1, d1);
    end
    @(negedge clk);
    checks++;
    if (d1 !== 1'b0) begin errors++; $display("FAIL abort_nodone got %b want 0", d1); end
    wr_ready = 1'b1;
    init1 = 1'b1;
    @(negedge clk);
    init1 = 1'b0;
    checks++;
    if (v1 !== 1'b1 || x1 !== 6'd10 || y1 !== 6'd20 || wd1 !== 8'hA5) begin
      errors++;
      $display("FAIL abort_restart got v=%b (%0d,%0d,%0h) want 1 (10,20,a5)", v1, x1, y1, wd1);
    end
    capture(0, 0, -1, 100);
    checks++;
    if (n_wr != 16 || done_at != 20) begin
      errors++; $display("FAIL abort_rerun got %0d writes done@%0d want 16 @20", n_wr, done_at);
    end
  endtask

  task automatic test_overlap();
    start(0, 10, 20, 3, 8'hA5, 8'h5A);
    capture(0, 0, 2, 100);
    checks++;
    if (n_wr != 16 || done_at != 20) begin
      errors++; $display("FAIL busy_init got %0d writes done@%0d want 16 @20", n_wr, done_at);
    end
    check_seq8("busy_init", 8'hA5, 8'h5A);
    @(negedge clk);
    x0 = 6'd30; init1 = 1'b1; abort = 1'b1;
    @(negedge clk);
    init1 = 1'b0; abort = 1'b0;
    checks++;
    if (b1 !== 1'b0 || v1 !== 1'b0) begin
      errors++; $display("FAIL init_abort got busy=%b v=%b want 0 0", b1, v1);
    end
    @(negedge clk);
    checks++;
    if (b1 !== 1'b0) begin errors++; $display("FAIL init_abort_hold got busy=%b want 0", b1); end
  endtask

  task automatic test_rst_midop();
    start(1, 3, 4, 3, 8'h42, 8'h24);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({v2, b2, ph2, d2} !== 4'h0 || {x2, y2, wd2} !== 20'h0) begin
      errors++;
      $display("FAIL rst_midop got ctrl=%b payload=%h want 0", {v2, b2, ph2, d2}, {x2, y2, wd2});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b2 !== 1'b0) begin errors++; $display("FAIL rst_midop_idle got busy=%b want 0", b2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_small();
    test_wrap();
    test_abort();
    test_overlap();
    test_rst_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
